frame_sequencer: RTL and testbench

- Sequences one image frame from a pixel source into the `top` processing pipeline.
- Accepts pixels over a valid/ready handshake and drives the pipeline's `en`, `hsync`, `vsync` and `data` inputs.
- Tracks raster x/y position.
- After the last pixel, flushes the pipeline with LATENCY zero-data enable cycles, then pulses `done`.

---
 rtl/frame_sequencer_if.sv | 33 +++
 rtl/frame_sequencer.sv | 134 +++++++++++++
 tb/tb_frame_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Pixel-source and pipeline-side signal bundle for frame_sequencer.
// Coordinate widths follow the frame geometry, with a minimum of 1 bit.
interface frame_sequencer_if #(
  parameter int unsigned WIDTH      = 32'd297,
  parameter int unsigned HEIGHT     = 32'd1,
  parameter int unsigned PIXEL_SIZE = 24
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                  start;
  logic                  src_valid;
  logic [PIXEL_SIZE-1:0] src_data;
  logic                  src_ready;
  logic                  en;
  logic                  hsync;
  logic                  vsync;
  logic [PIXEL_SIZE-1:0] data;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  busy;
  logic                  done;

  modport master (
    output start, src_valid, src_data,
    input  src_ready, en, hsync, vsync, data, x, y, busy, done
  );

  modport slave (
    input  start, src_valid, src_data,
    output src_ready, en, hsync, vsync, data, x, y, busy, done
  );
endinterface

// File: rtl/frame_sequencer.sv
// Feeds one raster frame into the pipeline, then LATENCY zero-data flush enables and a done pulse.
// Pixel to pipeline in 1 cycle; src_ready is high only in RUN, so the source stalls otherwise.
module frame_sequencer #(
  parameter int unsigned WIDTH      = 32'd297,
  parameter int unsigned HEIGHT     = 32'd1,
  parameter int unsigned PIXEL_SIZE = 24,
  parameter int unsigned LATENCY    = 4
) (
  input  logic              clk,
  input  logic              reset,
  frame_sequencer_if.slave  bus
);

  localparam int XW = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
  localparam int YW = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
  localparam int FW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [XW-1:0] LAST_COL   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] LAST_ROW   = YW'(HEIGHT - 1);
  localparam logic [FW-1:0] LAST_FLUSH = (LATENCY > 0) ? FW'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [XW-1:0]         col_q;
  logic [YW-1:0]         row_q;
  logic [FW-1:0]         flush_q;
  logic                  en_q;
  logic                  hsync_q;
  logic                  vsync_q;
  logic [PIXEL_SIZE-1:0] data_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= '0;
      en_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Strobes default low; data/x/y hold so a stalled pipeline sees stable values.
      en_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            col_q   <= '0;
            row_q   <= '0;
            flush_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        RUN: begin
          if (bus.src_valid) begin
            en_q    <= 1'b1;
            data_q  <= bus.src_data;
            x_q     <= col_q;
            y_q     <= row_q;
            hsync_q <= (col_q == '0);
            vsync_q <= (col_q == '0) && (row_q == '0);
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                row_q <= '0;
                if (LATENCY == 0) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end else begin
                  state_q <= FLUSH;
                end
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end

        FLUSH: begin
          // x/y keep the last pixel's coordinates while zeros drain the pipeline.
          en_q   <= 1'b1;
          data_q <= '0;
          if (flush_q == LAST_FLUSH) begin
            flush_q <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_ready = (state_q == RUN);
  assign bus.en        = en_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.data      = data_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench: a 4x2 frame with 3 flush cycles, and a 1x3 frame with no flush.
module tb_frame_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  frame_sequencer_if #(.WIDTH(4), .HEIGHT(2), .PIXEL_SIZE(24)) a_if ();
  frame_sequencer_if #(.WIDTH(1), .HEIGHT(3), .PIXEL_SIZE(24)) b_if ();

  frame_sequencer #(.WIDTH(4), .HEIGHT(2), .PIXEL_SIZE(24), .LATENCY(3)) u_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (a_if)
  );

  frame_sequencer #(.WIDTH(1), .HEIGHT(3), .PIXEL_SIZE(24), .LATENCY(0)) u_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector layout: {en, hsync, vsync, busy, done, src_ready, data, x, y}
  function automatic logic [32:0] obs_a();
    return {a_if.en, a_if.hsync, a_if.vsync, a_if.busy, a_if.done, a_if.src_ready,
            a_if.data, a_if.x, a_if.y};
  endfunction

  function automatic logic [32:0] obs_b();
    return {b_if.en, b_if.hsync, b_if.vsync, b_if.busy, b_if.done, b_if.src_ready,
            b_if.data, b_if.x, b_if.y};
  endfunction

  function automatic logic [32:0] pk_a(input logic en, input logic hs, input logic vs,
                                       input logic bz, input logic dn, input logic rd,
                                       input logic [23:0] d, input logic [1:0] x, input logic y);
    return {en, hs, vs, bz, dn, rd, d, x, y};
  endfunction

  function automatic logic [32:0] pk_b(input logic en, input logic hs, input logic vs,
                                       input logic bz, input logic dn, input logic rd,
                                       input logic [23:0] d, input logic x, input logic [1:0] y);
    return {en, hs, vs, bz, dn, rd, d, x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [32:0] oa, ob;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_if.start = 1'($urandom); a_if.src_valid = 1'($urandom); a_if.src_data = 24'($urandom);
      b_if.start = 1'($urandom); b_if.src_valid = 1'($urandom); b_if.src_data = 24'($urandom);
      step();
      oa = obs_a(); ob = obs_b();
      checks++;
      if (oa !== 33'h0) begin
        errors++; $display("FAIL reset_hold_a cycle %0d: got %h want 0", i, oa);
      end
      checks++;
      if (ob !== 33'h0) begin
        errors++; $display("FAIL reset_hold_b cycle %0d: got %h want 0", i, ob);
      end
    end
    a_if.start = 1'b0; b_if.start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.src_valid = 1'b1; a_if.src_data = 24'($urandom);
      b_if.src_valid = 1'b1; b_if.src_data = 24'($urandom);
      step();
      oa = obs_a(); ob = obs_b();
      checks++;
      if (oa !== 33'h0) begin
        errors++; $display("FAIL idle_no_start_a cycle %0d: got %h want 0", i, oa);
      end
      checks++;
      if (ob !== 33'h0) begin
        errors++; $display("FAIL idle_no_start_b cycle %0d: got %h want 0", i, ob);
      end
    end
    a_if.src_valid = 1'b0; b_if.src_valid = 1'b0;
  endtask

  // poke=1 pulses start during pixel 3, during FLUSH and in the DONE cycle.
  task automatic test_full_frame(input bit poke);
    logic [32:0] o, exp;
    int dones;
    int p;
    dones = 0;
    a_if.start = 1'b1; a_if.src_valid = 1'b0;
    step();
    a_if.start = 1'b0;
    o = obs_a();
    checks++;
    if (o[32:27] !== 6'b000101) begin
      errors++; $display("FAIL frame_run_entry poke=%0d: ctrl got %b want 000101", poke, o[32:27]);
    end
    for (int c = 1; c <= 13; c++) begin
      a_if.src_valid = (c - 1 < 8);
      a_if.src_data  = (c - 1 < 8) ? 24'(c - 1) : 24'hBADBAD;
      a_if.start     = poke && (c - 1 == 3 || c - 1 == 9 || c - 1 == 11);
      step();
      o = obs_a();
      if (c <= 8) begin
        p   = c - 1;
        exp = pk_a(1'b1, p % 4 == 0, p == 0, 1'b1, 1'b0, c < 8, 24'(p), 2'(p % 4), 1'(p / 4));
      end else if (c <= 11) begin
        exp = pk_a(1'b1, 1'b0, 1'b0, c <= 10, 1'b0, 1'b0, 24'h0, 2'd3, 1'b1);
      end else begin
        exp = pk_a(1'b0, 1'b0, 1'b0, 1'b0, c == 12, 1'b0, 24'h0, 2'd3, 1'b1);
      end
      if (o[28]) dones++;
      checks++;
      if (o !== exp) begin
        errors++; $display("FAIL frame_cycle poke=%0d c=%0d: got %h want %h", poke, c, o, exp);
      end
    end
    a_if.start = 1'b0; a_if.src_valid = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL frame_done_count poke=%0d: got %0d want 1", poke, dones);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] o, exp;
    int p, lastp;
    bit v;
    p = 0; lastp = 0;
    a_if.start = 1'b1; a_if.src_valid = 1'b0;
    step();
    a_if.start = 1'b0;
    o = obs_a();
    checks++;
    if (o[32:27] !== 6'b000101) begin
      errors++; $display("FAIL bp_run_entry: ctrl got %b want 000101", o[32:27]);
    end
    for (int k = 0; k < 22; k++) begin
      v = (k % 3 == 0);
      a_if.src_valid = v;
      a_if.src_data  = v ? 24'(p) : 24'hBADBAD;
      step();
      o = obs_a();
      if (v) begin
        exp = pk_a(1'b1, p % 4 == 0, p == 0, 1'b1, 1'b0, p != 7, 24'(p), 2'(p % 4), 1'(p / 4));
        lastp = p;
        p++;
      end else begin
        exp = pk_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'(lastp), 2'(lastp % 4), 1'(lastp / 4));
      end
      checks++;
      if (o !== exp) begin
        errors++; $display("FAIL bp_cycle k=%0d: got %h want %h", k, o, exp);
      end
    end
    a_if.src_valid = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      step();
      o = obs_a();
      if (f <= 3) exp = pk_a(1'b1, 1'b0, 1'b0, f < 3, 1'b0, 1'b0, 24'h0, 2'd3, 1'b1);
      else        exp = pk_a(1'b0, 1'b0, 1'b0, 1'b0, f == 4, 1'b0, 24'h0, 2'd3, 1'b1);
      checks++;
      if (o !== exp) begin
        errors++; $display("FAIL bp_flush f=%0d: got %h want %h", f, o, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [32:0] o;
    test_full_frame(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      o = obs_a();
      checks++;
      if (o[32:27] !== 6'b000000) begin
        errors++; $display("FAIL busy_start_idle i=%0d: ctrl got %b want 000000", i, o[32:27]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [32:0] o;
    a_if.start = 1'b1; a_if.src_valid = 1'b0;
    step();
    a_if.start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      a_if.src_valid = 1'b1;
      a_if.src_data  = 24'h000100 + 24'(p);
      step();
    end
    o = obs_a();
    checks++;
    if (o !== pk_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000105, 2'd1, 1'b1)) begin
      errors++; $display("FAIL midrst_pixel5: got %h want %h", o,
                         pk_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000105, 2'd1, 1'b1));
    end
    a_if.src_data = 24'h000106;
    #2;
    rst_n = 1'b0;
    #1;
    o = obs_a();
    checks++;
    if (o !== 33'h0) begin
      errors++; $display("FAIL midrst_async_clear: got %h want 0", o);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      o = obs_a();
      checks++;
      if (o !== 33'h0) begin
        errors++; $display("FAIL midrst_hold i=%0d: got %h want 0", i, o);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = obs_a();
      checks++;
      if (o !== 33'h0) begin
        errors++; $display("FAIL midrst_after_release i=%0d: got %h want 0", i, o);
      end
    end
    a_if.src_valid = 1'b0;
    test_full_frame(1'b0);
  endtask

  task automatic test_edge_geometry();
    logic [32:0] o, exp;
    int p;
    b_if.start = 1'b1; b_if.src_valid = 1'b0;
    step();
    b_if.start = 1'b0;
    o = obs_b();
    checks++;
    if (o[32:27] !== 6'b000101) begin
      errors++; $display("FAIL edge_run_entry: ctrl got %b want 000101", o[32:27]);
    end
    for (int c = 1; c <= 5; c++) begin
      b_if.src_valid = (c - 1 < 3);
      b_if.src_data  = (c - 1 < 3) ? {8'hB2, 8'hB1, 8'(c - 1)} : 24'hBADBAD;
      step();
      o = obs_b();
      if (c <= 3) begin
        p   = c - 1;
        exp = pk_b(1'b1, 1'b1, p == 0, c < 3, 1'b0, c < 3, {8'hB2, 8'hB1, 8'(p)}, 1'b0, 2'(p));
      end else begin
        exp = pk_b(1'b0, 1'b0, 1'b0, 1'b0, c == 4, 1'b0, {8'hB2, 8'hB1, 8'd2}, 1'b0, 2'd2);
      end
      checks++;
      if (o !== exp) begin
        errors++; $display("FAIL edge_cycle c=%0d: got %h want %h", c, o, exp);
      end
    end
    b_if.src_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a_if.start = 1'b0; a_if.src_valid = 1'b0; a_if.src_data = '0;
    b_if.start = 1'b0; b_if.src_valid = 1'b0; b_if.src_data = '0;
    #1;
    test_reset();
    test_full_frame(1'b0);
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    test_edge_geometry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
